// File: rtl/omap_wr_biu.sv
// Output-map write bus interface: buffers merger beats in a skid FIFO and
// streams them to the arbiter as one contiguous address region.
module omap_wr_biu #(
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_STEP  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    out_ch,
    input  logic [15:0]   map_size,
    input  logic [AW-1:0] omap_base_addr,
    input  logic          conv_start,
    input  logic          abort,
    input  logic [DW-1:0] map_merger2omap_biu_data,
    input  logic          map_merger2omap_biu_vld,
    output logic          map_merger2omap_biu_rdy,
    output logic          omap_biu2arb_req,
    output logic [AW-1:0] omap_biu2arb_addr,
    output logic [DW-1:0] omap_biu2arb_data,
    output logic          omap_biu2arb_vld,
    output logic          omap_biu2arb_last,
    input  logic          omap_biu2arb_rdy,
    output logic          omap_done,
    output logic          omap_busy
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = 24;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [TW-1:0] r_total;
    logic [TW-1:0] r_in_cnt;
    logic [TW-1:0] r_out_cnt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [TW-1:0] w_total;
    logic          w_run;
    logic          w_full;
    logic          w_empty;
    logic          w_in_rdy;
    logic          w_push;
    logic          w_out_vld;
    logic          w_pop;
    logic          w_last;
    logic          w_start;

    assign w_total   = TW'(map_size) * TW'(out_ch);
    assign w_run     = (r_state == S_RUN);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_in_rdy  = w_run && !w_full && (r_in_cnt < r_total);
    assign w_push    = w_in_rdy && map_merger2omap_biu_vld;
    assign w_out_vld = w_run && !w_empty;
    assign w_pop     = w_out_vld && omap_biu2arb_rdy;
    assign w_last    = w_out_vld && (r_out_cnt == (r_total - TW'(1)));
    assign w_start   = (r_state == S_IDLE) && conv_start;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; abort wins over everything, including a same-cycle start
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (conv_start) begin
                        w_state_nxt = (w_total == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_pop && w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Counters, pointers and address register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_total   <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_addr    <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else if (abort) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else if (w_start) begin
            r_total   <= w_total;
            r_addr    <= omap_base_addr;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                r_in_cnt <= r_in_cnt + TW'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PW'(1);
                r_out_cnt <= r_out_cnt + TW'(1);
                r_addr    <= r_addr + AW'(ADDR_STEP);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= map_merger2omap_biu_data;
        end
    end

    assign map_merger2omap_biu_rdy = w_in_rdy;
    assign omap_biu2arb_req        = w_run;
    assign omap_biu2arb_vld        = w_out_vld;
    assign omap_biu2arb_last       = w_last;
    assign omap_biu2arb_addr       = r_addr;
    assign omap_biu2arb_data       = w_out_vld ? r_mem[r_rd_ptr] : '0;
    assign omap_done               = (r_state == S_DONE);
    assign omap_busy               = w_run;

endmodule

// File: tb/tb_omap_wr_biu.sv
// Randomized self-checking bench for omap_wr_biu against a counting
// occupancy/sequence reference model.
module tb_omap_wr_biu;

    localparam int DEPTH = 4;
    localparam int STEP  = 1;

    logic        clk;
    logic        rst;
    logic [7:0]  out_ch;
    logic [15:0] map_size;
    logic [31:0] base_addr;
    logic        conv_start;
    logic        abort;
    logic [31:0] m_data;
    logic        m_vld;
    logic        m_rdy;
    logic        a_req;
    logic [31:0] a_addr;
    logic [31:0] a_data;
    logic        a_vld;
    logic        a_last;
    logic        a_rdy;
    logic        done;
    logic        busy;

    int checks;
    int failures;

    omap_wr_biu #(.DW(32), .AW(32), .FIFO_DEPTH(DEPTH), .ADDR_STEP(STEP)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .out_ch                  (out_ch),
        .map_size                (map_size),
        .omap_base_addr          (base_addr),
        .conv_start              (conv_start),
        .abort                   (abort),
        .map_merger2omap_biu_data(m_data),
        .map_merger2omap_biu_vld (m_vld),
        .map_merger2omap_biu_rdy (m_rdy),
        .omap_biu2arb_req        (a_req),
        .omap_biu2arb_addr       (a_addr),
        .omap_biu2arb_data       (a_data),
        .omap_biu2arb_vld        (a_vld),
        .omap_biu2arb_last       (a_last),
        .omap_biu2arb_rdy        (a_rdy),
        .omap_done               (done),
        .omap_busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: plain transfer, 1: abort while beat evt_beat is presented,
    // 2: reset pulse while beat evt_beat is presented
    task automatic run_xfer(input int ms, input int oc, input logic [31:0] base,
                            input int vld_pct, input int rdy_pct, input int stall,
                            input int mode, input int evt_beat, output int beats_out);
        int          total;
        logic [31:0] src[$];
        int          q_in, q_out, q_occ, cyc;
        bit          q_run, q_done, fin, evt, in_hs, out_hs, drv_vld, drv_rdy;
        logic        e_rdy, e_vld, e_last;
        logic [31:0] e_addr, e_data;
        logic [69:0] obs;
        total = ms * oc;
        for (int i = 0; i < total; i++) src.push_back($urandom);
        @(posedge clk); #1;
        map_size = 16'(ms); out_ch = 8'(oc); base_addr = base;
        conv_start = 1'b1; m_vld = 1'b0; a_rdy = 1'b0;
        #3;
        checks++;
        if (busy !== 1'b0 || a_vld !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL start_idle got busy=%b vld=%b done=%b exp 0/0/0", busy, a_vld, done);
        end
        @(posedge clk); #1;
        conv_start = 1'b0;
        q_run = (total != 0); q_done = (total == 0);
        q_in = 0; q_out = 0; q_occ = 0; cyc = 0; fin = 0;
        while (!fin && cyc < 3000) begin
            e_rdy  = q_run && q_occ < DEPTH && q_in < total;
            e_vld  = q_run && q_occ > 0;
            e_last = e_vld && (q_out == total - 1);
            e_addr = base + 32'(q_out * STEP);
            e_data = e_vld ? src[q_out] : 32'h0;
            drv_vld = ($urandom_range(99) < 32'(vld_pct));
            drv_rdy = (cyc >= stall) && ($urandom_range(99) < 32'(rdy_pct));
            m_vld  = drv_vld;
            m_data = (q_in < total) ? src[q_in] : $urandom;
            a_rdy  = drv_rdy;
            conv_start = q_run && ($urandom_range(7) == 0);
            if (conv_start) begin
                out_ch = 8'($urandom); map_size = 16'($urandom); base_addr = $urandom;
            end
            evt = (mode != 0) && e_vld && (q_out == evt_beat);
            abort = evt && (mode == 1);
            #3;
            checks++;
            if (m_rdy !== e_rdy) begin
                failures++; $display("FAIL up_rdy cyc=%0d got=%b exp=%b", cyc, m_rdy, e_rdy);
            end
            checks++;
            if (a_vld !== e_vld) begin
                failures++; $display("FAIL arb_vld cyc=%0d got=%b exp=%b", cyc, a_vld, e_vld);
            end
            checks++;
            if (a_req !== q_run || busy !== q_run) begin
                failures++; $display("FAIL req_busy cyc=%0d got=%b/%b exp=%b", cyc, a_req, busy, q_run);
            end
            checks++;
            if (done !== q_done) begin
                failures++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, q_done);
            end
            checks++;
            if (a_last !== e_last) begin
                failures++; $display("FAIL last cyc=%0d beat=%0d got=%b exp=%b", cyc, q_out, a_last, e_last);
            end
            if (e_vld) begin
                checks++;
                if (a_addr !== e_addr) begin
                    failures++; $display("FAIL addr beat=%0d got=%h exp=%h", q_out, a_addr, e_addr);
                end
                checks++;
                if (a_data !== e_data) begin
                    failures++; $display("FAIL data beat=%0d got=%h exp=%h", q_out, a_data, e_data);
                end
            end
            in_hs  = e_rdy && drv_vld;
            out_hs = e_vld && drv_rdy;
            if (q_done) fin = 1;
            if (evt && mode == 2) begin
                rst = 1'b1;
                #1;
                for (int k = 0; k < 2; k++) begin
                    obs = {a_req, a_vld, a_last, m_rdy, done, busy, a_addr, a_data};
                    checks++;
                    if (obs !== 70'h0) begin
                        failures++; $display("FAIL rst_outputs k=%0d got=%h exp=0", k, obs);
                    end
                    if (k == 0) begin @(posedge clk); #1; end
                end
                #2 rst = 1'b0;
                q_run = 0; q_done = 0; q_out = 0; fin = 1;
            end else begin
                @(posedge clk); #1;
                if (evt) begin
                    abort = 1'b0; m_vld = 1'b0; conv_start = 1'b0;
                    q_run = 0; q_out = 0; fin = 1;
                    for (int k = 0; k < 4; k++) begin
                        #3;
                        checks++;
                        if ({a_req, a_vld, m_rdy, done, busy} !== 5'b0) begin
                            failures++;
                            $display("FAIL post_abort k=%0d got req=%b vld=%b rdy=%b done=%b busy=%b exp 0",
                                     k, a_req, a_vld, m_rdy, done, busy);
                        end
                        @(posedge clk); #1;
                    end
                end else begin
                    q_done = 0;
                    if (out_hs && q_out == total - 1) begin
                        q_run = 0; q_done = 1;
                    end
                    q_in  += int'(in_hs);
                    q_out += int'(out_hs);
                    q_occ += int'(in_hs) - int'(out_hs);
                end
            end
            cyc++;
        end
        if (!fin) begin
            checks++; failures++;
            $display("FAIL timeout got cycles=%0d exp done within 3000", cyc);
        end
        m_vld = 1'b0; a_rdy = 1'b0; conv_start = 1'b0; abort = 1'b0;
        beats_out = q_out;
    endtask

    task automatic test_reset();
        logic [69:0] obs;
        rst = 1'b1; conv_start = 1'b0; abort = 1'b0; m_vld = 1'b0; a_rdy = 1'b0;
        m_data = '0; out_ch = '0; map_size = '0; base_addr = '0;
        repeat (2) @(posedge clk);
        #4;
        obs = {a_req, a_vld, a_last, m_rdy, done, busy, a_addr, a_data};
        checks++;
        if (obs !== 70'h0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", obs);
        end
        rst = 1'b0;
        @(posedge clk); #4;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_idle got busy=%b done=%b exp 0/0", busy, done);
        end
    endtask

    task automatic test_basic();
        int n;
        run_xfer(4, 2, 32'h1000, 100, 100, 0, 0, 0, n);
        checks++;
        if (n != 8) begin failures++; $display("FAIL basic_beats got=%0d exp=8", n); end
    endtask

    task automatic test_stall();
        int n;
        run_xfer(4, 2, 32'h1000, 100, 100, 10, 0, 0, n);
        checks++;
        if (n != 8) begin failures++; $display("FAIL stall_beats got=%0d exp=8", n); end
    endtask

    task automatic test_zero_len();
        int n;
        run_xfer(0, 5, 32'h40, 100, 100, 0, 0, 0, n);
        run_xfer(7, 0, 32'h80, 100, 100, 0, 0, 0, n);
        checks++;
        if (n != 0) begin failures++; $display("FAIL zero_beats got=%0d exp=0", n); end
    endtask

    task automatic test_abort();
        int n;
        run_xfer(4, 2, 32'h2000, 100, 100, 0, 1, 2, n);
        run_xfer(4, 2, 32'h2000, 100, 100, 0, 0, 0, n);
        checks++;
        if (n != 8) begin failures++; $display("FAIL abort_restart_beats got=%0d exp=8", n); end
    endtask

    task automatic test_abort_priority();
        @(posedge clk); #1;
        map_size = 16'd4; out_ch = 8'd2; conv_start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        conv_start = 1'b0; abort = 1'b0;
        #3;
        checks++;
        if (busy !== 1'b0 || a_req !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_priority got busy=%b req=%b done=%b exp 0/0/0", busy, a_req, done);
        end
    endtask

    task automatic test_wrap();
        int n;
        run_xfer(4, 1, 32'hFFFF_FFFE, 100, 100, 0, 0, 0, n);
        checks++;
        if (n != 4) begin failures++; $display("FAIL wrap_beats got=%0d exp=4", n); end
    endtask

    task automatic test_random();
        int n, ms, oc;
        for (int t = 0; t < 6; t++) begin
            ms = int'($urandom_range(1, 20));
            oc = int'($urandom_range(1, 4));
            run_xfer(ms, oc, $urandom, 60, 60, 0, 0, 0, n);
            checks++;
            if (n != ms * oc) begin
                failures++; $display("FAIL random_beats t=%0d got=%0d exp=%0d", t, n, ms * oc);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        run_xfer(6, 2, 32'h3000, 70, 50, 0, 2, int'($urandom_range(1, 8)), n);
        run_xfer(6, 2, 32'h3000, 70, 50, 0, 0, 0, n);
        checks++;
        if (n != 12) begin failures++; $display("FAIL reset_mid_beats got=%0d exp=12", n); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_abort();
        test_abort_priority();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/omap_wr_biu.md
OMAP_WR_BIU -- requirements
Module: omap_wr_biu

Interface
REQ-001 Parameter DW, default 32, data width of merger and arbiter data buses.
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter FIFO_DEPTH, default 4, skid FIFO entries; power of two, at least 2.
REQ-004 Parameter ADDR_STEP, default 1, address increment per transferred beat.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 out_ch  input  8  output channel count; sampled at start.
REQ-008 map_size  input  16  words per channel; sampled at start.
REQ-009 omap_base_addr  input  AW  first write address; sampled at start.
REQ-010 conv_start  input  1  single-cycle start pulse.
REQ-011 abort  input  1  synchronous cancel of the current transfer.
REQ-012 map_merger2omap_biu_data / _vld  input  DW / 1  upstream beat.
REQ-013 map_merger2omap_biu_rdy  output  1  upstream ready.
REQ-014 omap_biu2arb_req  output  1  bus request to the arbiter.
REQ-015 omap_biu2arb_addr / _data  output  AW / DW  write beat.
REQ-016 omap_biu2arb_vld / _last  output  1 / 1  beat valid; last beat of the map.
REQ-017 omap_biu2arb_rdy  input  1  arbiter ready.
REQ-018 omap_done  output  1  one-cycle pulse at transfer completion.
REQ-019 omap_busy  output  1  high in RUN.

Function
REQ-020 FSM states: IDLE, RUN, DONE.
REQ-021 Transfer length: total = map_size * out_ch, 24 bits unsigned, no truncation.
- Transfer is one continuous region; no per-channel wrap.
REQ-022 IDLE with conv_start=1:
- total, base address and address register are latched.
- Goes to RUN if total != 0; goes to DONE if total == 0.
REQ-023 conv_start outside IDLE is ignored.
REQ-024 map_merger2omap_biu_rdy = RUN && FIFO not full && in_cnt < total.
- Input handshake pushes the data into the FIFO and increments in_cnt.
REQ-025 The FIFO has no pass-through: a beat accepted in cycle N is first presented on the arbiter side in cycle N+1.
REQ-026 omap_biu2arb_vld = RUN && FIFO not empty; omap_biu2arb_data is the FIFO head.
REQ-027 Output handshake (vld && rdy):
- Pops the FIFO.
- Increments out_cnt.
- Adds ADDR_STEP to the address register, modulo 2^AW.
REQ-028 Data and address are held stable while vld=1 and rdy=0.
REQ-029 omap_biu2arb_addr = base + out_cnt * ADDR_STEP for the presented beat.
REQ-030 omap_biu2arb_last = vld && (out_cnt == total-1).
REQ-031 Push and pop in the same cycle are allowed when the FIFO is neither full nor empty beforehand; occupancy is unchanged.
REQ-032 When full, rdy=0 upstream; a same-cycle pop does not enable a push.
REQ-033 Handshake of the last beat: RUN -> DONE next cycle.
REQ-034 In DONE, omap_done=1 for exactly one cycle, then IDLE.
REQ-035 omap_biu2arb_req:
- Set on the cycle after the start is accepted with total != 0.
- Held high through RUN.
- Cleared on the cycle after the last-beat handshake.
REQ-036 abort=1 in any state:
- Next state IDLE; FIFO flushed; counters cleared.
- req, vld and upstream rdy go low next cycle.
- No omap_done pulse.
REQ-037 abort has priority over conv_start in the same cycle.

Reset
REQ-038 rst=1 immediately forces:
- State IDLE; FIFO empty; in_cnt=0, out_cnt=0; address register 0.
- All outputs 0: req, vld, last, upstream rdy, omap_done, omap_busy; addr=0, data=0.
REQ-039 rst asserted mid-transfer discards all buffered beats.
- After release the block waits in IDLE for a new conv_start.

Verification
REQ-040 map_size=4, out_ch=2, base=0x1000, arbiter rdy=1, merger vld=1:
- 8 beats at addr 0x1000..0x1007.
- last on the 0x1007 beat; omap_done one cycle after it; req low afterwards.
REQ-041 Same setup with arbiter rdy=0 for 10 cycles:
- Upstream rdy drops after 4 accepted beats.
- Addr and data held constant; no beat lost or duplicated after rdy=1.
REQ-042 map_size=0 or out_ch=0: DONE next cycle, omap_done pulse, req never asserted.
REQ-043 abort during beat 3 of 8:
- req, vld and upstream rdy low next cycle; no omap_done.
- A new conv_start restarts at base with the FIFO empty.
REQ-044 base=0xFFFFFFFE, ADDR_STEP=1, 4 beats: addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-045 rst pulse mid-transfer with random vld/rdy:
- All outputs 0 while rst=1.
- A subsequent full transfer matches the reference model beat for beat.
